// File: rtl/fib_seq_accel_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fib_seq_accel_if - Avalon-MM slave bus bundle for fib_seq_accel
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
interface fib_seq_accel_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, read, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, read, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/fib_seq_accel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fib_seq_accel - polled Fibonacci accelerator (COUNT / NTH modes),
//           optional interrupt via macro FIB_SEQ_ACCEL_IRQ_EN
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
module fib_seq_accel #(
  parameter int DATA_W = 32,
  parameter int ITER_W = 8
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  fib_seq_accel_if.slave bus
`ifdef FIB_SEQ_ACCEL_IRQ_EN
  , output logic         irq
`endif
);

  localparam int c_CMP_W = (DATA_W > ITER_W) ? DATA_W : ITER_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_arg;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W:0]     r_b;
  logic [ITER_W-1:0]   r_k;
  logic [DATA_W-1:0]   r_result;
  logic [ITER_W-1:0]   r_iter;
  logic                r_mode;
  logic                r_ovf;

  logic w_wr_ctrl;
  logic w_wr_arg;
  logic w_abort;
  logic w_start;
  logic w_ack;
  logic w_term;
  logic w_ie;
  logic w_unused;

  assign w_wr_ctrl = bus.chipselect && bus.write && (bus.address == 2'd0);
  assign w_wr_arg  = bus.chipselect && bus.write && (bus.address == 2'd1);
  assign w_abort   = w_wr_ctrl && bus.writedata[2];
  assign w_start   = w_wr_ctrl && bus.writedata[0] && (r_state != S_RUN);
  assign w_term    = r_mode ? (c_CMP_W'(r_k) == c_CMP_W'(r_arg)) : (r_a >= r_arg);
  assign w_unused  = &{1'b0, bus.read, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_arg    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_iter   <= '0;
      r_mode   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_arg && (r_state != S_RUN)) begin
        r_arg <= bus.writedata[DATA_W-1:0];
      end
      // ABORT outranks START in the same write; START is blocked while running.
      if (w_abort) begin
        r_state <= S_IDLE;
      end else if (w_start) begin
        r_mode  <= bus.writedata[1];
        r_ovf   <= 1'b0;
        r_a     <= '0;
        r_b     <= (DATA_W+1)'(1);
        r_k     <= '0;
        r_state <= S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_term) begin
              r_result <= r_mode ? r_a : DATA_W'(r_k);
              r_iter   <= r_k;
              r_state  <= S_DONE;
            end else if (r_b[DATA_W]) begin
              r_ovf    <= 1'b1;
              r_result <= '0;
              r_iter   <= r_k;
              r_state  <= S_DONE;
            end else begin
              r_a <= r_b[DATA_W-1:0];
              r_b <= {1'b0, r_a} + r_b;
              r_k <= r_k + 1'b1;
            end
          end
          S_DONE: begin
            if (w_ack) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FIB_SEQ_ACCEL_IRQ_EN
  logic r_ie;
  logic r_irq;
  logic w_ie_next;
  logic w_done_next;

  assign w_ack       = w_wr_ctrl && bus.writedata[4];
  assign w_ie        = r_ie;
  assign w_ie_next   = w_wr_ctrl ? bus.writedata[3] : r_ie;
  // Mirrors the next DONE state so irq rises together with done.
  assign w_done_next = !w_abort && !w_start &&
                       (((r_state == S_RUN) && (w_term || r_b[DATA_W])) ||
                        ((r_state == S_DONE) && !w_ack));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ie  <= w_ie_next;
      r_irq <= w_ie_next && w_done_next;
    end
  end

  assign irq = r_irq;
`else
  assign w_ack = 1'b0;
  assign w_ie  = 1'b0;
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = {27'd0, w_ie, r_mode, r_ovf,
                            (r_state == S_DONE), (r_state == S_RUN)};
      2'd1: bus.readdata = 32'(r_arg);
      2'd2: bus.readdata = 32'(r_result);
      default: bus.readdata = 32'(r_iter);
    endcase
  end

endmodule
`default_nettype wire

// File: doc/fib_seq_accel.md
Name: fib_seq_accel

Overview:
- Avalon-MM slave Fibonacci accelerator; parametrised successor to the single-mode terms-to-limit core.
- Two modes:
  - COUNT: smallest index k with F(k) >= ARG.
  - NTH: F(ARG).
- Adds a status register, overflow detection, abort, and an iteration readback.
- Sits on the HPS lightweight bridge as a polled peripheral, with an optional IRQ.

Parameters:
- DATA_W, 32, arithmetic width of terms and ARG; legal 8..32; readdata zero-extended to 32.
- ITER_W, 8, width of the iteration counter k; must hold 2*DATA_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- read  in  1  read strobe, qualified by chipselect; no side effects.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational mux on address, read latency 0, no wait states.

Behaviour:
- Sequence: F0=0, F1=1, F(k+2)=F(k)+F(k+1).
- Register map (word addresses):
  - 0 CTRL/STATUS:
    - Write: bit0 START, bit1 MODE (0=COUNT, 1=NTH), bit2 ABORT.
    - Read: bit0 busy, bit1 done, bit2 overflow, bit3 mode, rest 0.
  - 1 ARG: RW, DATA_W bits, zero-extended on read.
  - 2 RESULT: RO.
  - 3 ITER: RO, final k.
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: all registers 0; readdata = 0 at address 0.
- START written in IDLE or DONE:
  - Latch MODE; clear done and overflow.
  - Load a=0, b=1 (b is DATA_W+1 bits), k=0.
  - Enter RUN next cycle; busy=1 from that cycle.
- RUN, one evaluation per clock, first match wins:
  1. Terminate (COUNT: a >= ARG; NTH: k == ARG): RESULT=a in NTH, k in COUNT; ITER=k; go to DONE.
  2. Overflow (b[DATA_W]==1): overflow=1, RESULT=0, ITER=k; go to DONE.
  3. Otherwise advance: a<=b[DATA_W-1:0], b<=a+b, k<=k+1.
- Latency: RUN lasts exactly ITER+1 cycles; done=1 on the following cycle.
- DONE: busy=0, done=1; holds until next START, ABORT or reset.
- START while busy (RUN): ignored entirely.
- ABORT (bit2 set, any state; has priority over START in the same write):
  - Go to IDLE; busy=0, done=0.
  - RESULT and ITER keep previous values.
- ARG writes while busy: ignored. ARG writes in IDLE or DONE: take effect.
- Writes to addresses 2 and 3: ignored.
- reset_n low mid-run: immediate return to IDLE, all state cleared.
- Simultaneous write and read: read returns pre-write contents.
- ARG=0: terminates on the first RUN cycle in both modes; RESULT=0, ITER=0.

Optional Feature:
- Macro: FIB_SEQ_ACCEL_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, registered).
  - CTRL bit3 = IE (RW, read back at status bit4); CTRL bit4 = DONE_ACK (write-1 clears done).
  - irq = done & IE; deasserts the cycle after DONE_ACK, ABORT, START or reset.
- When undefined:
  - No irq port.
  - Bits 3/4 on write ignored; status bit4 reads 0.

Test Plan:
- NTH, ARG=10, START -> busy for 11 cycles, then RESULT=55, ITER=10, status=0b1010 (done, mode=1).
- COUNT, ARG=100 -> RESULT=12 (F11=89, F12=144), ITER=12, overflow=0; ARG=13 -> RESULT=7.
- DATA_W=32 boundaries:
  - NTH ARG=47 -> RESULT=2971215073, overflow=0.
  - NTH ARG=48 -> overflow=1, RESULT=0, ITER=47.
  - COUNT ARG=0xFFFFFFFF -> overflow=1.
- ARG=0 in both modes -> RUN exactly 1 cycle, RESULT=0, ITER=0.
- Start NTH ARG=30; during run:
  - Second START with ARG=5 -> ignored; final RESULT=832040.
  - Separate run: ABORT at cycle 10 -> busy=0, done=0, RESULT unchanged.
- reset_n pulsed low mid-run (asynchronous, between edges) -> all status/RESULT/ITER read 0 immediately; with FIB_SEQ_ACCEL_IRQ_EN, IE=1 run ARG=5 -> irq=1 with done, DONE_ACK -> irq=0 next cycle.
